// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// byte-enable type and the address-error rule used by the responder.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef logic [3:0] be_t;

   localparam int DEPTH_WORDS_DEF = 1024;
   localparam int WAIT_CYCLES_DEF = 2;

   // Misaligned, or word index beyond the end of the array.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a CPU-side master and the memory responder.
interface dmem_if;
   import dmem_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   be_t         req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word array with per-byte write enables.
// Read data is registered and only updates on enabled cycles.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic          en,
   input  be_t           we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, performs the
// array access on the edge entering RESP, then holds the response until taken.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   dmem_if.slave bus
);

   localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   be_t         be_reg;
   logic        ready_reg;
   logic        valid_reg;
   logic        err_reg;
   logic        rd_hit_reg;

   logic        accept;
   logic        go_resp;
   logic        acc_we;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   be_t         acc_be;
   logic        acc_err;
   logic        mem_en;
   be_t         mem_we;
   logic [31:0] mem_rdata;

   assign accept  = (state_reg == IDLE) && bus.req_valid;
   assign go_resp = (accept && (WAIT_CYCLES == 0)) || ((state_reg == WAIT) && (cnt_reg == 4'd0));

   // With zero wait the access happens on the accept edge, so it must use
   // the live request rather than the (not yet loaded) request registers.
   assign acc_we    = (state_reg == IDLE) ? bus.req_we    : we_reg;
   assign acc_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
   assign acc_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;
   assign acc_be    = (state_reg == IDLE) ? bus.req_be    : be_reg;
   assign acc_err   = addr_err(acc_addr, DEPTH_WORDS);

   // Gating with reset_n drops a write whose RESP edge coincides with reset.
   assign mem_en = go_resp && !acc_err && reset_n;
   assign mem_we = acc_we ? acc_be : 4'b0000;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (acc_addr[AW+1:2]),
      .wdata (acc_wdata),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= 4'd0;
         ready_reg  <= 1'b1;
         valid_reg  <= 1'b0;
         err_reg    <= 1'b0;
         rd_hit_reg <= 1'b0;
      end else begin
         if (accept) begin
            we_reg    <= bus.req_we;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            be_reg    <= bus.req_be;
         end
         if (go_resp) begin
            state_reg  <= RESP;
            ready_reg  <= 1'b0;
            valid_reg  <= 1'b1;
            err_reg    <= acc_err;
            rd_hit_reg <= !acc_we && !acc_err;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (accept) begin
                     state_reg <= WAIT;
                     cnt_reg   <= WAIT_INIT;
                     ready_reg <= 1'b0;
                  end
               end
               WAIT: begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
               RESP: begin
                  if (bus.rsp_ready) begin
                     state_reg  <= IDLE;
                     ready_reg  <= 1'b1;
                     valid_reg  <= 1'b0;
                     err_reg    <= 1'b0;
                     rd_hit_reg <= 1'b0;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  ready_reg <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.req_ready = ready_reg;
   assign bus.rsp_valid = valid_reg;
   assign bus.rsp_err   = err_reg;
   assign bus.rsp_rdata = rd_hit_reg ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with WAIT_CYCLES=2 for the
// directed vectors and one with WAIT_CYCLES=0 for back-to-back throughput.
module tb_dmem_responder;
   import dmem_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      be_t         be;
      logic [31:0] erd;
      logic        eerr;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_if bus ();
   dmem_if bus0 ();

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus.slave)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus0.slave)
   );

   exp_t q2[$];
   exp_t q0[$];
   vec_t vecs[$];
   vec_t b0[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Monitor for the WAIT_CYCLES=2 instance.
   int   first2 = 0;
   logic pv2 = 1'b0;
   exp_t e2;
   always begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid === 1'b1 && pv2 !== 1'b1) first2 = cyc;
      pv2 = bus.rsp_valid;
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
         if (q2.size() == 0) begin
            tmo("unexpected_rsp");
         end else begin
            e2 = q2.pop_front();
            chk("rdata", bus.rsp_rdata, e2.rdata);
            chk("err", 32'(bus.rsp_err), 32'(e2.err));
            chk("latency", 32'(first2 - e2.acc), 32'd3);
            $display("txn w2: rdata=%h err=%0b latency=%0d", bus.rsp_rdata, bus.rsp_err, first2 - e2.acc);
         end
      end
   end

   // Monitor for the WAIT_CYCLES=0 instance.
   int   first0 = 0;
   int   last0 = -1;
   logic pv0 = 1'b0;
   exp_t e0;
   always begin
      @(negedge clk);
      #1;
      if (bus0.rsp_valid === 1'b1 && pv0 !== 1'b1) first0 = cyc;
      pv0 = bus0.rsp_valid;
      if (bus0.rsp_valid === 1'b1 && bus0.rsp_ready === 1'b1) begin
         if (q0.size() == 0) begin
            tmo("unexpected_rsp0");
         end else begin
            e0 = q0.pop_front();
            chk("rdata0", bus0.rsp_rdata, e0.rdata);
            chk("err0", 32'(bus0.rsp_err), 32'(e0.err));
            chk("latency0", 32'(first0 - e0.acc), 32'd1);
            if (last0 >= 0) chk("gap0", 32'(cyc - last0), 32'd2);
            $display("txn w0: rdata=%h err=%0b latency=%0d", bus0.rsp_rdata, bus0.rsp_err, first0 - e0.acc);
         end
         last0 = cyc;
      end
   end

   // Issue one request on the W2 instance; junk is driven during WAIT to
   // confirm the inputs are ignored there.
   task automatic txn(input vec_t v);
      int n;
      n = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = v.we;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.req_be    = v.be;
      while (bus.req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.req_ready !== 1'b1) begin
         tmo("req_ready");
         bus.req_valid = 1'b0;
         return;
      end
      q2.push_back('{v.erd, v.eerr, cyc});
      @(negedge clk);
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h10;
      bus.req_wdata = 32'h0;
      bus.req_be    = 4'hF;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q2.size() != 0 || q0.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q2.size() != 0 || q0.size() != 0) begin
         tmo("drain");
         q2.delete();
         q0.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_be = 0;
      bus.rsp_ready = 1;
      bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0; bus0.req_be = 0;
      bus0.rsp_ready = 1;

      vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
      vecs.push_back('{1'b0, 32'h13,   32'h0,        4'h0, 32'h0,        1'b1});
      vecs.push_back('{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b1});
      vecs.push_back('{1'b1, 32'h0,    32'h11223344, 4'hF, 32'h0,        1'b0});
      vecs.push_back('{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
      vecs.push_back('{1'b0, 32'h0,    32'h0,        4'h0, 32'h11223344, 1'b0});
      vecs.push_back('{1'b1, 32'h10,   32'h0,        4'h0, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEAA, 1'b0});
      vecs.push_back('{1'b1, 32'h14,   32'h0,        4'hF, 32'h0,        1'b0});
      vecs.push_back('{1'b1, 32'h14,   32'hAABBCCDD, 4'h6, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h14,   32'h0,        4'h0, 32'h00BBCC00, 1'b0});
      vecs.push_back('{1'b1, 32'h12,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
      vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
      vecs.push_back('{1'b1, 32'h20,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0});

      b0.push_back('{1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'h0,        1'b0});
      b0.push_back('{1'b1, 32'h4, 32'h600DCAFE, 4'hF, 32'h0,        1'b0});
      b0.push_back('{1'b0, 32'h0, 32'h0,        4'h0, 32'h0BADF00D, 1'b0});
      b0.push_back('{1'b0, 32'h4, 32'h0,        4'h0, 32'h600DCAFE, 1'b0});
      b0.push_back('{1'b0, 32'h3, 32'h0,        4'h0, 32'h0,        1'b1});
      b0.push_back('{1'b0, 32'h0, 32'h0,        4'h0, 32'h0BADF00D, 1'b0});

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("reset_req_ready0", 32'(bus0.req_ready), 32'd1);

      foreach (vecs[i]) txn(vecs[i]);
      drain();

      // Response held while the requester stalls.
      bus.rsp_ready = 1'b0;
      txn('{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0});
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.rsp_valid !== 1'b1) tmo("stall_rsp_valid");
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
         chk("stall_rdata", bus.rsp_rdata, 32'hDEADBEAA);
         chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      chk("consume_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      chk("after_consume_req_ready", 32'(bus.req_ready), 32'd1);
      chk("after_consume_valid", 32'(bus.rsp_valid), 32'd0);
      drain();

      // Reset during WAIT of a write: the write must be abandoned.
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_wdata = 32'h12345678;
      bus.req_be    = 4'hF;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("in_wait_req_ready", 32'(bus.req_ready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_wait_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_wait_rsp_rdata", bus.rsp_rdata, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      txn('{1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0});
      drain();

      // Back-to-back on the zero-wait instance with req_valid held high.
      @(negedge clk);
      foreach (b0[i]) begin
         n = 0;
         while (bus0.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (bus0.req_ready !== 1'b1) begin
            tmo("req_ready0");
            break;
         end
         bus0.req_valid = 1'b1;
         bus0.req_we    = b0[i].we;
         bus0.req_addr  = b0[i].addr;
         bus0.req_wdata = b0[i].wdata;
         bus0.req_be    = b0[i].be;
         q0.push_back('{b0[i].erd, b0[i].eerr, cyc});
         @(negedge clk);
      end
      bus0.req_valid = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra cycles between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  the CPU side presents a request.
REQ-006 SHALL have port req_ready  output  1  the block accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port req_be  input  4  byte enables; bit i selects wdata[8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  requester consumes the response.
REQ-013 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-017 SHALL accept a request on a cycle where req_valid=1 and req_ready=1, and register we/addr/wdata/be on that edge.
REQ-018 After an accept, SHALL go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise SHALL go directly to RESP.
REQ-019 In WAIT, SHALL decrement the counter each cycle and enter RESP on the cycle after the counter reaches 0.
REQ-020 SHALL perform the array access on the edge that enters RESP: a write updates only the bytes with be=1; a read latches the full word into rsp_rdata.
REQ-021 Latency: an accept at edge T SHALL give rsp_valid=1 after edge T+1+WAIT_CYCLES.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-023 SHALL NOT accept a new request on the cycle a response is consumed; req_ready rises the following cycle.
REQ-024 Error: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS SHALL give rsp_err=1 and rsp_rdata=0, with no array write.
REQ-025 A write with be=4'b0000 SHALL complete normally (rsp_err=0) with no array change.
REQ-026 Reads SHALL ignore req_be.
REQ-027 SHALL ignore req_* inputs in WAIT and RESP.

Reset
REQ-028 While reset_n=0 at an edge, SHALL set state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready SHALL read 1 after reset.
REQ-029 Reset in WAIT or RESP SHALL abandon the transaction; a pending write not yet performed SHALL NOT occur.
REQ-030 Reset SHALL NOT clear array contents.

Structure
REQ-031 Package dmem_pkg SHALL hold the FSM state typedef, the default DEPTH_WORDS, the default WAIT_CYCLES, and a 4-bit byte-enable typedef.
REQ-032 The storage SHALL be a sub-module dmem_array: single port, synchronous, byte-write-enabled, DEPTH_WORDS x 32.

Verification
REQ-033 Reset, then write addr 0x10, wdata 0xDEADBEEF, be 0xF; read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after accept (WAIT_CYCLES=2).
REQ-034 Write 0x10, wdata 0x000000AA, be 0x1 over 0xDEADBEEF -> a read returns 0xDEADBEAA.
REQ-035 Read at 0x13 (misaligned) and at 0x1000 (DEPTH_WORDS=1024) -> rsp_err=1, rsp_rdata=0; a write to 0x1000 leaves word 0 unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable and req_ready=0 throughout; after the rsp_ready pulse, req_ready=1 on the next cycle.
REQ-037 Assert reset_n=0 during WAIT of a write of 0x12345678 to 0x20 -> state IDLE, rsp_valid=0; a read of 0x20 returns its prior value.
REQ-038 With WAIT_CYCLES=0, back-to-back reads with rsp_ready tied to 1 -> one response every 2 cycles, latency 1 cycle.
